// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, reads a combinational ROM and buffers
// fetched words in a small in-order prefetch queue for decode.
//
// Handshake: out_valid is high whenever the queue holds an entry; the head entry
// moves to decode on any rising edge where out_valid & out_ready are both high.
// While out_valid is high and out_ready is low, out_inst/out_pc stay unchanged.
// redirect_valid is sampled on every edge and needs no ready; it wins over
// everything except rst.
module if_fetch_ctrl #(
   parameter int unsigned       ADDR_W    = 64,
   parameter int unsigned       INST_W    = 32,
   parameter int unsigned       DEPTH     = 4,
   parameter logic [ADDR_W-1:0] RESET_PC  = '0,
   parameter int unsigned       MEM_BYTES = 1024,
   localparam int unsigned      CNT_W     = $clog2(DEPTH + 1),
   localparam int unsigned      PTR_W     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [INST_W-1:0] rom_inst,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [INST_W-1:0] out_inst,
   output logic [ADDR_W-1:0] out_pc,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              halted,
   output logic              fault,
   output logic [ADDR_W-1:0] fault_pc,
   output logic [CNT_W-1:0]  occupancy,
   output logic [1:0]        state_dbg
);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      HALT  = 2'd1,
      FAULT = 2'd2
   } state_t;

   localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W + 1)'(MEM_BYTES);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   state_t            state_q;
   logic [ADDR_W-1:0] fetch_pc_q;
   logic              halted_q;
   logic              fault_q;
   logic [ADDR_W-1:0] fault_pc_q;

   logic [ADDR_W-1:0] pc_mem_q   [DEPTH];
   logic [INST_W-1:0] inst_mem_q [DEPTH];
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;

   logic [ADDR_W:0]   fetch_end;
   logic              aligned;
   logic              in_range;
   logic              fetch_ok;
   logic              q_full;
   logic              q_empty;
   logic              push;
   logic              pop;

   // Range check carries one extra bit so a PC near 2^ADDR_W cannot wrap into range.
   assign fetch_end = {1'b0, fetch_pc_q} + (ADDR_W + 1)'(4);
   assign aligned   = (fetch_pc_q[1:0] == 2'b00);
   assign in_range  = (fetch_end <= MEM_LIMIT);
   assign fetch_ok  = aligned && in_range;

   assign q_full  = (count_q == FULL_CNT);
   assign q_empty = (count_q == '0);

   // Fullness is judged before any same-cycle pop, giving a one-bubble refill.
   assign push = (state_q == RUN) && fetch_ok && (rom_inst != '0) && !q_full;
   assign pop  = !q_empty && out_ready;

   // Sequencer FSM with its registered status flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= RUN;
         fetch_pc_q <= RESET_PC;
         halted_q   <= 1'b0;
         fault_q    <= 1'b0;
         fault_pc_q <= '0;
      end else if (redirect_valid) begin
         state_q    <= RUN;
         fetch_pc_q <= redirect_pc;
         halted_q   <= 1'b0;
         fault_q    <= 1'b0;
      end else begin
         case (state_q)
            RUN: begin
               if (!fetch_ok) begin
                  state_q    <= FAULT;
                  fault_q    <= 1'b1;
                  fault_pc_q <= fetch_pc_q;
               end else if (rom_inst == '0) begin
                  state_q  <= HALT;
                  halted_q <= 1'b1;
               end else if (!q_full) begin
                  fetch_pc_q <= fetch_pc_q + ADDR_W'(4);
               end
            end
            HALT:    state_q <= HALT;
            FAULT:   state_q <= FAULT;
            default: state_q <= RUN;
         endcase
      end
   end

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (redirect_valid) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         if (push && !pop)      count_d = count_q + CNT_W'(1);
         else if (!push && pop) count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: count_q gates visibility of every slot.
   always_ff @(posedge clk) begin
      if (push && !redirect_valid && !rst) begin
         pc_mem_q[wr_ptr_q]   <= fetch_pc_q;
         inst_mem_q[wr_ptr_q] <= rom_inst;
      end
   end

   assign rom_addr  = fetch_pc_q;
   assign out_valid = !q_empty;
   assign out_pc    = q_empty ? '0 : pc_mem_q[rd_ptr_q];
   assign out_inst  = q_empty ? '0 : inst_mem_q[rd_ptr_q];
   assign halted    = halted_q;
   assign fault     = fault_q;
   assign fault_pc  = fault_pc_q;
   assign occupancy = count_q;
   assign state_dbg = state_q;

endmodule
